// File: rtl/switch_conditioner.sv
// Four-channel push-button conditioner: 2-flop synchroniser, per-channel debounce,
// registered press/release pulses. Optional auto-repeat under SWITCH_AUTOREPEAT_EN.
module switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 6250000,
  parameter int REPEAT_PERIOD   = 1250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [3:0] i_Switch,
  output logic [3:0] o_Switch_Level,
  output logic [3:0] o_Press_Pulse,
  output logic [3:0] o_Release_Pulse,
  output logic [3:0] o_Repeat_Pulse,
  output logic       o_Any_Press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
  end

  logic [3:0]       sync_p0;
  logic [3:0]       sync_p1;
  logic [CNT_W-1:0] dbc_cnt [4];
  logic [3:0]       stable;
  logic [3:0]       press_p2;
  logic [3:0]       release_p2;
  logic             any_p2;
  logic [3:0]       accept;

  // Stage p0/p1: synchroniser into i_Clk
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= i_Switch;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    accept = '0;
    for (int i = 0; i < 4; i++) begin
      accept[i] = (sync_p1[i] != stable[i]) && (dbc_cnt[i] == CNT_LAST);
    end
  end

  // Stage p2: debounce counters, accepted level and edge pulses
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < 4; i++) begin
        dbc_cnt[i] <= '0;
      end
      stable     <= '0;
      press_p2   <= '0;
      release_p2 <= '0;
      any_p2     <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] != stable[i]) begin
          if (accept[i]) begin
            stable[i]  <= sync_p1[i];
            dbc_cnt[i] <= '0;
          end else begin
            dbc_cnt[i] <= dbc_cnt[i] + CNT_W'(1);
          end
        end else begin
          dbc_cnt[i] <= '0;
        end
      end
      press_p2   <= accept & sync_p1;
      release_p2 <= accept & ~sync_p1;
      any_p2     <= |(accept & sync_p1);
    end
  end

  assign o_Switch_Level  = stable;
  assign o_Press_Pulse   = press_p2;
  assign o_Release_Pulse = release_p2;
  assign o_Any_Press     = any_p2;

`ifdef SWITCH_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT_LAST  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt [4];
  logic [3:0]       rpt_first;
  logic [3:0]       rpt_p2;

  // Stage p2: repeat timers run only while the accepted level holds at 1;
  // a release accepted this cycle takes the clearing branch.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < 4; i++) begin
        rpt_cnt[i] <= '0;
      end
      rpt_first <= '0;
      rpt_p2    <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept[i] && sync_p1[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_first[i] <= 1'b1;
          rpt_p2[i]    <= 1'b1;
        end else if (stable[i] && !accept[i]) begin
          if (rpt_cnt[i] == (rpt_first[i] ? RPT_FIRST_LAST : RPT_NEXT_LAST)) begin
            rpt_cnt[i]   <= '0;
            rpt_first[i] <= 1'b0;
            rpt_p2[i]    <= 1'b1;
          end else begin
            rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
            rpt_p2[i]  <= 1'b0;
          end
        end else begin
          rpt_cnt[i]   <= '0;
          rpt_first[i] <= 1'b0;
          rpt_p2[i]    <= 1'b0;
        end
      end
    end
  end

  assign o_Repeat_Pulse = rpt_p2;
`else
  assign o_Repeat_Pulse = press_p2;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner: directed scenarios plus random switching,
// checked every cycle against a window-based behavioural model.
module tb_switch_conditioner;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic [3:0] lvl, prs, rel, rpt;
  logic       any;

  always #5 clk = ~clk;

  switch_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .i_Switch(sw),
    .o_Switch_Level(lvl),
    .o_Press_Pulse(prs),
    .o_Release_Pulse(rel),
    .o_Repeat_Pulse(rpt),
    .o_Any_Press(any)
  );

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
    logic       any;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  // Model state: raw samples seen at the last D+2 edges, accepted level, held cycles
  bit   hist [4][$];
  bit   lvl_m [4];
  int   hold [4];

  function automatic out_t model_edge(logic [3:0] s, logic r);
    out_t o;
    bit   flip;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      if (!r) begin
        hist[i].delete();
        for (int k = 0; k < D + 2; k++) hist[i].push_back(1'b0);
        lvl_m[i] = 1'b0;
        hold[i]  = 0;
      end else begin
        hist[i].push_back(s[i]);
        void'(hist[i].pop_front());
        // Level changes once the raw input seen D..D+1 edges ago has disagreed
        // with it for D consecutive edges (two edges are lost to synchronisation).
        flip = 1'b1;
        for (int j = 0; j < D; j++) if (hist[i][j] == lvl_m[i]) flip = 1'b0;
        if (flip) begin
          lvl_m[i] = ~lvl_m[i];
          if (lvl_m[i]) begin
            o.prs[i] = 1'b1;
            o.rpt[i] = 1'b1;
            hold[i]  = 0;
          end else begin
            o.rel[i] = 1'b1;
          end
        end else if (lvl_m[i]) begin
          hold[i]++;
`ifdef SWITCH_AUTOREPEAT_EN
          if (hold[i] == RD || (hold[i] > RD && (hold[i] - RD) % RP == 0)) o.rpt[i] = 1'b1;
`endif
        end
        o.lvl[i] = lvl_m[i];
      end
    end
    o.any = |o.prs;
    return o;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      exp_q.push_back(model_edge(sw, rst_n));
      @(negedge clk);
    end
  endtask

  // Monitor: every output cycle is compared against the oldest expectation
  initial begin
    out_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{lvl: lvl, prs: prs, rel: rel, rpt: rpt, any: any};
        checks++;
        if (a === e) passes++;
        else $display("FAIL outputs cyc=%0d got lvl=%b prs=%b rel=%b rpt=%b any=%b exp lvl=%b prs=%b rel=%b rpt=%b any=%b",
                      cyc, a.lvl, a.prs, a.rel, a.rpt, a.any, e.lvl, e.prs, e.rel, e.rpt, e.any);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    sw    = 4'b0000;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Clean press and release on channel 0
    sw[0] = 1'b1; tick(20);
    sw[0] = 1'b0; tick(12);

    // Bounce shorter than the debounce window on channel 1
    sw[1] = 1'b1; tick(3);
    sw[1] = 1'b0; tick(1);
    sw[1] = 1'b1; tick(2);
    sw[1] = 1'b0; tick(3);
    tick(8);

    // Simultaneous press on channels 1 and 3
    sw = 4'b1010; tick(10);
    sw = 4'b0000; tick(10);

    // Held button on channel 2 for repeat cadence
    sw[2] = 1'b1; tick(26);
    sw[2] = 1'b0; tick(15);

    // Reset while channel 0 is held high
    sw[0] = 1'b1; tick(10);
    rst_n = 1'b0; tick(2);
    rst_n = 1'b1; tick(10);
    sw[0] = 1'b0; tick(10);

    // Long hold on channel 3; its debounce counter must sit at zero
    sw[3] = 1'b1; tick(1000);
    checks++;
    if (dut.dbc_cnt[3] == '0) passes++;
    else $display("FAIL long_hold_cnt got=%0d exp=0", dut.dbc_cnt[3]);
    sw[3] = 1'b0; tick(10);

    // Random switching with occasional resets
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) sw[b] = ~sw[b];
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick($urandom_range(1, 2));
        rst_n = 1'b1;
      end
      tick(1);
    end
    sw = 4'b0000; tick(12);

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

Input-conditioning stage between the four board push-buttons and the Pong game logic (paddles, ball serve, game-state control). It synchronises each raw switch into `i_Clk`, debounces it with a per-channel counter, and produces clean levels plus single-cycle press and release pulses. With the auto-repeat build option it also produces timed repeat pulses for held buttons, which drive smooth paddle motion. All outputs are registered and reset cleanly, so downstream blocks can rely on one event per physical press.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 250000 — consecutive stable cycles needed to accept a new level (10 ms at 25 MHz); must be ≥ 1.
- `REPEAT_DELAY`, 6250000 — cycles from press to first auto-repeat pulse (250 ms); must be ≥ 1.
- `REPEAT_PERIOD`, 1250000 — cycles between subsequent repeat pulses (50 ms); must be ≥ 1.

Ports:
- `i_Clk` input 1 — system clock, 25 MHz pixel clock; all logic is on the rising edge.
- `i_Rst_L` input 1 — asynchronous, active-low reset.
- `i_Switch` input 4 — raw, asynchronous, bouncing switches; bit0 = Switch_1 … bit3 = Switch_4.
- `o_Switch_Level` output 4 — debounced level per channel.
- `o_Press_Pulse` output 4 — one-cycle pulse on each accepted 0→1.
- `o_Release_Pulse` output 4 — one-cycle pulse on each accepted 1→0.
- `o_Repeat_Pulse` output 4 — press pulse plus auto-repeat pulses; see Configuration.
- `o_Any_Press` output 1 — OR of the `o_Press_Pulse` bits; used as the start/serve trigger.

## Operation
- The four channels are identical and fully independent.
- **Synchroniser:** a 2-flop chain per channel. Only the second stage, `sync`, is used downstream.
- **Debounce:**
  - Each channel has a counter, width `$clog2(DEBOUNCE_CYCLES+1)`, and a stable register.
  - While `sync != stable`, the counter increments each cycle.
  - When `sync == stable`, the counter clears to 0.
  - On the cycle that `sync != stable` and `counter == DEBOUNCE_CYCLES-1`:
    - `stable <= sync`
    - `counter <= 0`
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes the level.
- **Pulses:**
  - `o_Press_Pulse[i]` is registered high in exactly the cycle where `o_Switch_Level[i]` first reads 1.
  - `o_Release_Pulse[i]` is registered high in exactly the cycle where `o_Switch_Level[i]` first reads 0.
  - Press and release pulses can never be high together on one channel.
- **Simultaneous events:** several channels may pulse in the same cycle. `o_Any_Press` is the OR of those bits in that same cycle.
- **Reset:**
  - Every register clears immediately on `i_Rst_L` low, including synchronisers, counters, levels and repeat timers. All outputs go to 0.
  - A switch held through reset yields a fresh press pulse once debounced after reset release.
  - No release pulse is ever generated by reset itself.

## Timing
- **Press latency:** if `i_Switch[i]` is high at rising edges 1 … N, then `o_Switch_Level[i]` and `o_Press_Pulse[i]` go high after edge `DEBOUNCE_CYCLES+2`. Release latency is the same.
- **Pulse width:** exactly one cycle.
- **Minimum accepted pulse width:** `DEBOUNCE_CYCLES` synchronised cycles.
- **Counter overflow:** the counter never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.
- **Repeat timing:** the repeat counter counts held cycles after the press pulse.
  - First repeat arrives `REPEAT_DELAY` cycles after the press pulse.
  - Later repeats arrive every `REPEAT_PERIOD` cycles.
  - Release clears the repeat counter in the release-pulse cycle. No repeat pulse may occur in that cycle or later.

## Configuration
- Macro: `SWITCH_AUTOREPEAT_EN`.
- **Defined:** `o_Repeat_Pulse[i]` pulses in the press cycle, then at the `REPEAT_DELAY` / `REPEAT_PERIOD` cadence while the level stays 1. A per-channel repeat counter and a first-repeat flag are built.
- **Undefined:** `o_Repeat_Pulse` is wired equal to `o_Press_Pulse`. The repeat counters and the `REPEAT_*` parameters are unused and no repeat logic is synthesised.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=8`, `REPEAT_PERIOD=3`.
- **Clean press/release:** set `i_Switch[0]` high for 20 cycles, then low.
  - Level rises at edge 6 after the input rise.
  - One `o_Press_Pulse[0]` and one `o_Any_Press`.
  - Level falls 6 edges after the input fall, with one release pulse.
  - Other bits stay 0.
- **Bounce rejection:** toggle `i_Switch[1]` high 3 cycles, low 1, high 2, low 3.
  - Level, press and release stay 0 throughout.
- **Simultaneous press:** raise `i_Switch[3:0]=4'b1010` on the same edge.
  - `o_Press_Pulse=4'b1010` in one cycle.
  - `o_Any_Press` high for exactly that cycle.
- **Auto-repeat (macro defined):** hold `i_Switch[2]` for 20 cycles after its press pulse.
  - Repeat pulses at press+0, +8, +11, +14, +17.
  - After release, no further repeat pulses.
  - With the macro undefined, only the press+0 pulse appears.
- **Reset mid-operation:** assert `i_Rst_L=0` for 2 cycles while `i_Switch[0]` is held and level is 1.
  - All outputs are 0 during reset, with no release pulse.
  - After reset release, a new press pulse arrives at edge 6.
- **Long hold:** hold `i_Switch[3]` for 1000 cycles.
  - Exactly one press pulse; level remains 1; the debounce counter stays 0.
